ar_mux41_rr: RTL and testbench
==============================

// Module: ar_mux41_rr
// PURPOSE
//   Registered 4:1 round-robin merge: gathers beats from four lanes onto one output.
//   Reverse direction of the 1:4 lane demux: out_sel carries the source lane index in
//   the same 2-bit encoding the demux uses as sel (00->lane0 ... 11->lane3).
//   Sits upstream of a demux or any single-stream consumer; valid/ready on all sides.
// PARAMETERS
//   WIDTH  8  data bits per lane
// PORTS
//   clk        in   1          single clock; all state updates on rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   enable     in   1          1 = arbitration allowed; 0 = no new beats accepted
//   in_valid   in   4          per-lane valid, bit i = lane i
//   in_data    in   4*WIDTH    lane i data at [i*WIDTH +: WIDTH]
//   in_ready   out  4          per-lane accept, one-hot or zero (combinational)
//   out_valid  out  1          output register holds a beat
//   out_data   out  WIDTH      registered beat data
//   out_sel    out  2          lane index the held beat came from
//   out_ready  in   1          downstream accepts beat when out_valid & out_ready
// BEHAVIOUR
//   Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=2'b00, ptr=2'b00.
//     Reset mid-transfer drops the held beat; no in_ready asserted while rst_n=0.
//   State: 1-entry output register (EMPTY when out_valid=0, FULL when 1) + 2-bit ptr.
//   Slot free: free = ~out_valid | out_ready (drain and refill in same cycle allowed).
//   Grant: g = first lane with in_valid=1 scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//   load = enable & |in_valid & free.
//   in_ready[i] = load & (g==i); never more than one bit set; zero when load=0.
//   in_ready must not depend on in_data; it may depend on in_valid, out_ready, enable.
//   On load edge: out_data<=lane g data, out_sel<=g, out_valid<=1, ptr<=g+1 (wraps 3->0).
//   Else if out_valid & out_ready: out_valid<=0; out_data/out_sel hold last value.
//   Else: all registers hold (FULL with out_ready=0 stalls; inputs back-pressured).
//   Latency: lane accepted at edge N -> visible on out_* after edge N (1 cycle).
//   Throughput: 1 beat/cycle with out_ready held high.
//   ptr advances only on a load; idle cycles and enable=0 do not move it.
//   enable=0: no loads, in_ready=0; an already-held beat still drains normally.
//   Fairness: with all four lanes valid continuously, grant order is strict
//     rotation; any lane waits at most 3 other beats.
//   Lane dropping in_valid before accept is legal; it is simply skipped.
//   No X propagation: out_data updates only on load.
// TESTING
//   1 Reset: rst_n=0 at any time -> out_valid=0, out_sel=0, out_data=0, in_ready=0 async.
//   2 Single lane: enable=1, in_valid=4'b0100, lane2 data=8'hA5, out_ready=1 -> in_ready=
//     4'b0100 one cycle, next cycle out_valid=1, out_data=8'hA5, out_sel=2'b10.
//   3 Rotation: in_valid=4'b1111 held, out_ready=1, lane i data=8'h10+i -> out_sel sequence
//     0,1,2,3,0 on consecutive cycles, out_data 10,11,12,13,10.
//   4 Backpressure: out_valid=1, out_ready=0 for 5 cycles, in_valid=4'b0011 -> in_ready=0,
//     out_data stable; out_ready=1 -> drain and next lane loaded same edge.
//   5 Enable: enable=0 with in_valid=4'b1111 -> in_ready=0, ptr frozen; held beat drains;
//     re-enable resumes rotation from the lane after the last grant.
//   6 Wrap/skip: ptr=3, in_valid=4'b0010 -> lane1 granted, ptr becomes 2'b10.

Source files
------------

// File: rtl/ar_mux41_rr.sv
// rtl/ar_mux41_rr.sv - registered 4:1 round-robin lane merge with valid/ready on all sides
// Lane index of the held beat is reported on out_sel using the 1:4 demux sel encoding.
module ar_mux41_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_sel_q,   out_sel_d;
  logic [1:0]       ptr_q,       ptr_d;

  logic [7:0]       valid_dbl;
  logic [3:0]       valid_rot;
  logic [1:0]       offset;
  logic [1:0]       grant;
  logic             any_valid;
  logic             free;
  logic             load;

  // Rotate so that bit 0 is the lane at ptr, then take the lowest set bit.
  assign valid_dbl = {in_valid, in_valid} >> ptr_q;
  assign valid_rot = valid_dbl[3:0];
  assign any_valid = |in_valid;

  always_comb begin
    offset = 2'd0;
    if (valid_rot[0])      offset = 2'd0;
    else if (valid_rot[1]) offset = 2'd1;
    else if (valid_rot[2]) offset = 2'd2;
    else if (valid_rot[3]) offset = 2'd3;
  end

  assign grant = ptr_q + offset;
  assign free  = ~out_valid_q | out_ready;
  // rst_n gating keeps in_ready low while reset is held, before any edge arrives.
  assign load  = rst_n & enable & any_valid & free;

  always_comb begin
    in_ready = 4'b0000;
    if (load) in_ready[grant] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant*WIDTH +: WIDTH];
      out_sel_d   = grant;
      ptr_d       = grant + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'b00;
      ptr_q       <= 2'b00;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_ar_mux41_rr.sv
// tb/tb_ar_mux41_rr.sv - table-driven bench for ar_mux41_rr
// Each row drives one cycle of inputs, checks in_ready before the edge and out_* after it.
module tb_ar_mux41_rr;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int tests_run;
  int tests_failed;

  ar_mux41_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  localparam logic [31:0] D0 = 32'h13121110;
  localparam logic [31:0] DA = 32'h13A51110;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    in_valid  = 4'b0000;
    in_data   = D0;
    out_ready = 1'b0;

    //               rst en  iv       data ordy  ir      ov   od     os
    tbl.push_back('{1'b1, 1'b1, 4'b0100, DA, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2}); // single lane
    tbl.push_back('{1'b1, 1'b1, 4'b0000, DA, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2}); // drain, hold data
    tbl.push_back('{1'b0, 1'b1, 4'b1111, D0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0}); // reset mid-run
    tbl.push_back('{1'b1, 1'b1, 4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0}); // rotation
    tbl.push_back('{1'b1, 1'b1, 4'b1111, D0, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, D0, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, D0, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0});
    for (int i = 0; i < 5; i++)                                                  // backpressure
      tbl.push_back('{1'b1, 1'b1, 4'b0011, D0, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0});
    tbl.push_back('{1'b1, 1'b1, 4'b0011, D0, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1}); // drain+refill
    tbl.push_back('{1'b1, 1'b1, 4'b0011, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0}); // skip 2,3
    tbl.push_back('{1'b1, 1'b0, 4'b1111, D0, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0}); // enable=0 hold
    tbl.push_back('{1'b1, 1'b0, 4'b1111, D0, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0}); // drains
    tbl.push_back('{1'b1, 1'b0, 4'b1111, D0, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0}); // ptr frozen
    tbl.push_back('{1'b1, 1'b1, 4'b1111, D0, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1}); // resumes lane1
    tbl.push_back('{1'b1, 1'b1, 4'b0100, D0, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2}); // ptr -> 3
    tbl.push_back('{1'b1, 1'b1, 4'b0010, D0, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1}); // wrap to lane1
    tbl.push_back('{1'b1, 1'b1, 4'b1011, D0, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3}); // ptr was 2
    tbl.push_back('{1'b1, 1'b1, 4'b0000, D0, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3}); // stall empty in
    tbl.push_back('{1'b1, 1'b1, 4'b0000, D0, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3}); // drain

    repeat (2) @(negedge clk);
    enable   = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("reset_in_ready",  in_ready,  4'b0000);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data",  out_data,  8'h00);
    chk("reset_out_sel",   out_sel,   2'd0);
    in_valid = 4'b0000;

    foreach (tbl[k]) begin
      @(negedge clk);
      rst_n     = tbl[k].rst_n;
      enable    = tbl[k].en;
      in_valid  = tbl[k].iv;
      in_data   = tbl[k].d;
      out_ready = tbl[k].ordy;
      #1;
      chk($sformatf("row%0d_in_ready", k), in_ready, tbl[k].ir);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_out_valid", k), out_valid, tbl[k].ov);
      chk($sformatf("row%0d_out_data", k),  out_data,  tbl[k].od);
      chk($sformatf("row%0d_out_sel", k),   out_sel,   tbl[k].os);
    end

    // Async reset between edges while a beat is held and lanes request.
    @(negedge clk);
    enable    = 1'b1;
    in_valid  = 4'b1000;
    in_data   = D0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("async_pre_valid", out_valid, 1'b1);
    chk("async_pre_data",  out_data,  8'h13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_data",  out_data,  8'h00);
    chk("async_out_sel",   out_sel,   2'd0);
    chk("async_in_ready",  in_ready,  4'b0000);

    // After release ptr restarts at lane 0.
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b1010;
    #1;
    chk("post_reset_grant", in_ready, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
